lb_cpu_bridge: RTL and testbench

LB_CPU_BRIDGE -- requirements
Module: lb_cpu_bridge

---
 rtl/lb_cpu_bridge.sv | 145 ++++++++++++++
 tb/tb_lb_cpu_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_cpu_bridge.sv
// lb_cpu_bridge: local-bus initiator turning single CPU load/store requests into
// register-block write/read cycles. One transaction at a time; cpu_req is only
// looked at in IDLE, so nothing is queued while busy.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be -> cpu_ack, cpu_rdata, cpu_err, busy
//   Bus write: waddr, wdata, wstrb, wen -> wready
//   Bus read : raddr, ren -> rdata, rvalid
//
// Latency: write with immediate wready -> cpu_ack 2 cycles after the request cycle;
// read with rvalid one cycle after ren -> 3 cycles.
//
// Optional feature macro LB_TIMEOUT_EN: bounds the wait in WRITE / RD_WAIT to
// TIMEOUT_CYC cycles and completes with cpu_err=1. Without it the bridge waits
// forever and cpu_err is tied low.
module lb_cpu_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [STRB_W-1:0] cpu_be,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              busy,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen,
    output logic [STRB_W-1:0] wstrb,
    input  logic              wready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state;
    state_t state_n;
    logic   accept;
    logic   tmo_hit;

    assign accept = (state == IDLE) && cpu_req;

    // Bus strobes and handshake outputs are pure state decodes; since the state
    // register resets synchronously they all read 0 after the reset edge.
    assign busy    = (state != IDLE);
    assign wen     = (state == WRITE);
    assign ren     = (state == RD_REQ);
    assign cpu_ack = (state == RESP);

`ifdef LB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter holds the number of completed cycles in the current wait state;
    // it fires on the TIMEOUT_CYC-th waiting cycle, i.e. as it reaches TIMEOUT_CYC.
    assign tmo_hit = (state == WRITE || state == RD_WAIT) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_n != state) begin
            tmo_cnt <= '0;
        end else if (state == WRITE || state == RD_WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Handshake has priority over the timeout, so the error only sets when the
    // wait state is abandoned without its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_err <= 1'b0;
        end else if (accept) begin
            cpu_err <= 1'b0;
        end else if (tmo_hit && ((state == WRITE && !wready) ||
                                 (state == RD_WAIT && !rvalid))) begin
            cpu_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cpu_req) state_n = cpu_we ? WRITE : RD_REQ;
            WRITE:   if (wready || tmo_hit) state_n = RESP;
            RD_REQ:  state_n = RD_WAIT;
            RD_WAIT: if (rvalid || tmo_hit) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture. Both address ports take the word-aligned address so they
    // stay stable until the next acceptance whatever the direction. cpu_rdata is
    // cleared on acceptance so writes and timed-out reads return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr     <= '0;
            raddr     <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            cpu_rdata <= '0;
        end else if (accept) begin
            waddr     <= cpu_addr & ~ADDR_W'(3);
            raddr     <= cpu_addr & ~ADDR_W'(3);
            wdata     <= cpu_wdata;
            wstrb     <= cpu_be;
            cpu_rdata <= '0;
        end else if (state == RD_WAIT && rvalid) begin
            cpu_rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_lb_cpu_bridge.sv
// tb_lb_cpu_bridge: scoreboard bench for lb_cpu_bridge. Expected bus cycles and
// CPU responses are queued when a request is driven and popped by monitors
// when the DUT produces them. A small responder models the register block.
module tb_lb_cpu_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        busy;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;

    always #5 clk = ~clk;

    lb_cpu_bridge #(
        .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .busy(busy),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
        .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          start;
        int          lat;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: wready after wr_stall low cycles of wen; rvalid one cycle after ren.
    int          wr_stall   = 0;
    bit          rd_resp_en = 1'b1;
    logic [31:0] rd_val     = 32'h0;
    logic        rv_resp    = 1'b0;
    logic        rv_stray   = 1'b0;
    logic        ren_prev   = 1'b0;
    int          wcnt       = 0;

    assign rvalid = rv_resp | rv_stray;
    assign rdata  = rd_val;

    initial wready = 1'b0;

    always @(negedge clk) begin
        if (wen) begin
            wready = (wcnt >= wr_stall);
            wcnt++;
        end else begin
            wready = 1'b0;
            wcnt   = 0;
        end
        rv_resp  = ren_prev && rd_resp_en;
        ren_prev = ren;
    end

    // Monitors: bus cycles and CPU responses against the scoreboard.
    logic wen_d = 1'b0;
    logic ren_d = 1'b0;
    logic ack_d = 1'b0;
    int   wlen  = 0;
    int   wlen_exp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wen || ren) check("bus_overlap", {63'd0, wen & ren}, 64'd0);
            if (wen && !wen_d) begin
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected_wr", 64'd1, 64'd0);
                end else begin
                    bus_t b;
                    b = exp_bus.pop_front();
                    check("bus_dir_wr", {63'd0, b.we}, 64'd1);
                    check("waddr", {32'd0, waddr}, {32'd0, b.addr});
                    check("wdata", {32'd0, wdata}, {32'd0, b.data});
                    check("wstrb", {60'd0, wstrb}, {60'd0, b.strb});
                    wlen_exp = b.len;
                end
                wlen = 0;
            end
            if (wen) wlen++;
            if (!wen && wen_d) check("wen_len", 64'(wlen), 64'(wlen_exp));
            if (ren) begin
                check("ren_pulse", {63'd0, ren_d}, 64'd0);
                if (!ren_d) begin
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected_rd", 64'd1, 64'd0);
                    end else begin
                        bus_t b;
                        b = exp_bus.pop_front();
                        check("bus_dir_rd", {63'd0, b.we}, 64'd0);
                        check("raddr", {32'd0, raddr}, {32'd0, b.addr});
                    end
                end
            end
            if (cpu_ack) begin
                ack_cnt++;
                check("ack_pulse", {63'd0, ack_d}, 64'd0);
                if (exp_rsp.size() == 0) begin
                    check("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, r.rdata});
                    check("cpu_err", {63'd0, cpu_err}, {63'd0, r.err});
                    if (r.lat >= 0) check("ack_latency", 64'(cyc - r.start), 64'(r.lat));
                end
            end
        end
        wen_d = wen;
        ren_d = ren;
        ack_d = cpu_ack;
    end

    task automatic push_exp(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_rd,
                            input bit exp_err, input int lat);
        bus_t b;
        rsp_t r;
        b.we    = we;
        b.addr  = addr & 32'hFFFF_FFFC;
        b.data  = wd;
        b.strb  = be;
        b.len   = wr_stall + 1;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.start = cyc;
        r.lat   = lat;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_ack(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {63'd0, ok}, 64'd1);
    endtask

    // Called at a negedge: queue expectations, raise the request, hold it until ack.
    task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd,
                        input bit exp_err, input int lat);
        push_exp(we, addr, wd, be, exp_rd, exp_err, lat);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_be    = be;
        wait_ack("ack_seen");
        cpu_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},   {63'd0, cpu_ack}, 64'd0);
        check({tag, "_err"},   {63'd0, cpu_err}, 64'd0);
        check({tag, "_rdata"}, {32'd0, cpu_rdata}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy}, 64'd0);
        check({tag, "_wen"},   {63'd0, wen}, 64'd0);
        check({tag, "_ren"},   {63'd0, ren}, 64'd0);
        check({tag, "_waddr"}, {32'd0, waddr}, 64'd0);
        check({tag, "_raddr"}, {32'd0, raddr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
        check({tag, "_wstrb"}, {60'd0, wstrb}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_before;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // Basic write, then hold of latched values after completion.
        xfer(1'b1, 32'h8, 32'h41, 4'h1, 32'h0, 1'b0, 2);
        repeat (2) @(negedge clk);
        check("hold_waddr", {32'd0, waddr}, 64'h8);
        check("hold_wdata", {32'd0, wdata}, 64'h41);
        check("hold_wstrb", {60'd0, wstrb}, 64'h1);

        // Basic read.
        rd_val = 32'h3;
        xfer(1'b0, 32'h4, 32'h0, 4'h0, 32'h3, 1'b0, 3);
        @(negedge clk);

        // Write with all byte enables off still makes a bus cycle.
        xfer(1'b1, 32'h24, 32'hDEAD_BEEF, 4'h0, 32'h0, 1'b0, 2);
        @(negedge clk);

        // Read with a wide data pattern and unaligned address.
        rd_val = 32'hA5C3_0F96;
        xfer(1'b0, 32'h1_0007, 32'h0, 4'hF, 32'hA5C3_0F96, 1'b0, 3);
        @(negedge clk);

        // Stall: 5 cycles of wready low; a request raised mid-transfer is ignored.
        wr_stall = 5;
        push_exp(1'b1, 32'h13, 32'h1234_5678, 4'hC, 32'h0, 1'b0, 7);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h13;
        cpu_wdata = 32'h1234_5678; cpu_be = 4'hC;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("stall_busy", {63'd0, busy}, 64'd1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        repeat (2) @(negedge clk);
        cpu_req = 1'b0;
        wait_ack("stall_ack_seen");
        wr_stall = 0;
        repeat (3) @(negedge clk);

        // Back-to-back: request held across the first ack.
        rd_val = 32'h5A;
        push_exp(1'b1, 32'h0, 32'h77, 4'h3, 32'h0, 1'b0, -1);
        push_exp(1'b0, 32'hC, 32'h0, 4'h0, 32'h5A, 1'b0, -1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h77; cpu_be = 4'h3;
        wait_ack("b2b_ack1");
        cpu_we = 1'b0; cpu_addr = 32'hC;
        wait_ack("b2b_ack2");
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);

`ifdef LB_TIMEOUT_EN
        // Timeout on a read that never returns, then a stray rvalid.
        rd_resp_en = 1'b0;
        rd_val = 32'hFFFF_FFFF;
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 18);
        acks_before = ack_cnt;
        @(negedge clk);
        rv_stray = 1'b1;
        @(negedge clk);
        rv_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_stray_no_ack", 64'(ack_cnt), 64'(acks_before));
        rd_resp_en = 1'b1;
`endif

        // Reset while waiting for read data, then a late rvalid.
        rd_resp_en = 1'b0;
        push_exp(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, -1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rdwait_busy", {63'd0, busy}, 64'd1);
        acks_before = ack_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rsp.delete();
        rv_stray = 1'b1;
        @(negedge clk);
        rv_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_ack", 64'(ack_cnt), 64'(acks_before));
        check_zero("midrst");
        rd_resp_en = 1'b1;

        check("bus_left", 64'(exp_bus.size()), 64'd0);
        check("rsp_left", 64'(exp_rsp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
